// File: rtl/alu_pkg.sv
// alu_pkg: shared op/state encodings and popcount helper for the alu_acc datapath
package alu_pkg;
  localparam int POP_MAX = 256;
  typedef enum logic [1:0] {
    OP_XNOR = 2'b00,
    OP_MUL  = 2'b01,
    OP_XOR  = 2'b10,
    OP_NONE = 2'b11
  } op_t;
  typedef enum logic [1:0] {ACCUM, DRAIN, HOLD} state_t;
  // Callers zero-extend their operand to POP_MAX bits first, so unused high bits count nothing.
  function automatic logic [31:0] popcount(input logic [POP_MAX-1:0] v);
    popcount = '0;
    for (int i = 0; i < POP_MAX; i++) popcount = popcount + 32'(v[i]);
  endfunction
endpackage

// File: rtl/alu_lane.sv
// alu_lane: one combinational lane computing XNOR-popcount, signed multiply or XOR-popcount
//   op     : operation for this beat
//   a, b   : lane operands
//   result : 2*DATA_WIDTH result; products sign-extended, popcounts zero-extended
module alu_lane import alu_pkg::*; #(
  parameter int DATA_WIDTH = 32
) (
  input  op_t                     op,
  input  logic [DATA_WIDTH-1:0]   a,
  input  logic [DATA_WIDTH-1:0]   b,
  output logic [2*DATA_WIDTH-1:0] result
);
  localparam int RW = 2 * DATA_WIDTH;
  logic [DATA_WIDTH-1:0] x, xn;
  logic signed [RW-1:0] prod;
  assign x    = a ^ b;
  assign xn   = ~x;
  assign prod = RW'($signed(a)) * RW'($signed(b));
  always_comb begin
    result = op == OP_MUL  ? prod :
             op == OP_XNOR ? RW'(popcount(POP_MAX'(xn))) :
             op == OP_XOR  ? RW'(popcount(POP_MAX'(x))) : '0;
  end
endmodule

// File: rtl/alu_acc.sv
// alu_acc: multi-lane ALU whose per-beat lane sum is accumulated over a vector, valid/ready on both sides
//   clk_i, rst_ni           : clock, asynchronous active-low reset
//   op_i                    : operation, taken from the first beat of each vector
//   in_valid_i/in_ready_o   : beat handshake carrying a_i, b_i, last_i
//   out_valid_o/out_ready_i : result handshake carrying acc_o and count_o
module alu_acc import alu_pkg::*; #(
  parameter int DATA_WIDTH = 32,
  parameter int LANES      = 4,
  parameter int ACC_WIDTH  = 48
) (
  input  logic                        clk_i,
  input  logic                        rst_ni,
  input  logic [1:0]                  op_i,
  input  logic                        in_valid_i,
  output logic                        in_ready_o,
  input  logic [LANES*DATA_WIDTH-1:0] a_i,
  input  logic [LANES*DATA_WIDTH-1:0] b_i,
  input  logic                        last_i,
  output logic                        out_valid_o,
  input  logic                        out_ready_i,
  output logic [ACC_WIDTH-1:0]        acc_o,
  output logic [15:0]                 count_o
);
  localparam int RW = 2 * DATA_WIDTH;
  // Reduction width never below a lane result, so sign extension is exact; the
  // final slice to ACC_WIDTH is the intended modulo wrap.
  localparam int SW = ACC_WIDTH > RW ? ACC_WIDTH : RW;
  state_t state, state_nx;
  op_t op_q, op_eff;
  logic first_q, s1_valid, accept;
  logic [ACC_WIDTH-1:0] s1_sum, acc;
  logic [15:0] count;
  logic signed [RW-1:0] lane_res [LANES];
  logic signed [SW-1:0] beat_sum;
  assign accept = in_valid_i & in_ready_o;
  assign op_eff = first_q ? op_t'(op_i) : op_q;
  for (genvar k = 0; k < LANES; k++) begin : g_lane
    alu_lane #(.DATA_WIDTH(DATA_WIDTH)) u_lane (
      .op    (op_eff),
      .a     (a_i[k*DATA_WIDTH +: DATA_WIDTH]),
      .b     (b_i[k*DATA_WIDTH +: DATA_WIDTH]),
      .result(lane_res[k])
    );
  end
  always_comb begin
    beat_sum = '0;
    for (int i = 0; i < LANES; i++) beat_sum = beat_sum + SW'(lane_res[i]);
  end
  always_comb begin
    state_nx = state == ACCUM ? (accept && last_i ? DRAIN : ACCUM) :
               state == DRAIN ? HOLD : (out_ready_i ? ACCUM : HOLD);
    in_ready_o  = state == ACCUM;
    out_valid_o = state == HOLD;
  end
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state    <= ACCUM;
      first_q  <= 1'b1;
      op_q     <= OP_XNOR;
      s1_valid <= 1'b0;
      s1_sum   <= '0;
      acc      <= '0;
      count    <= '0;
    end else begin
      state    <= state_nx;
      s1_valid <= accept;
      if (accept) begin
        s1_sum  <= beat_sum[ACC_WIDTH-1:0];
        first_q <= last_i;
        count   <= count + 16'(count != 16'hFFFF);
        if (first_q) op_q <= op_eff;
      end
      if (s1_valid) acc <= acc + s1_sum;
      if (state == HOLD && out_ready_i) begin
        acc     <= '0;
        count   <= '0;
        first_q <= 1'b1;
      end
    end
  end
  assign acc_o   = acc;
  assign count_o = count;
endmodule

// File: tb/tb_alu_acc.sv
// tb_alu_acc: directed checks of alu_acc at 8-bit x 4 lanes, with a 24-bit and a 16-bit accumulator in lockstep
module tb_alu_acc;
  logic        clk_i = 1'b0;
  logic        rst_ni = 1'b0;
  logic [1:0]  op_i = 2'b00;
  logic        in_valid_i = 1'b0;
  logic        last_i = 1'b0;
  logic        out_ready_i = 1'b0;
  logic [31:0] a_i = '0, b_i = '0;
  logic        in_ready0, out_valid0, in_ready1, out_valid1;
  logic [23:0] acc0;
  logic [15:0] acc1, count0, count1;
  int checks = 0;
  int failures = 0;

  always #5 clk_i = ~clk_i;

  alu_acc #(.DATA_WIDTH(8), .LANES(4), .ACC_WIDTH(24)) dut0 (
    .clk_i(clk_i), .rst_ni(rst_ni), .op_i(op_i), .in_valid_i(in_valid_i), .in_ready_o(in_ready0),
    .a_i(a_i), .b_i(b_i), .last_i(last_i), .out_valid_o(out_valid0), .out_ready_i(out_ready_i),
    .acc_o(acc0), .count_o(count0)
  );
  alu_acc #(.DATA_WIDTH(8), .LANES(4), .ACC_WIDTH(16)) dut1 (
    .clk_i(clk_i), .rst_ni(rst_ni), .op_i(op_i), .in_valid_i(in_valid_i), .in_ready_o(in_ready1),
    .a_i(a_i), .b_i(b_i), .last_i(last_i), .out_valid_o(out_valid1), .out_ready_i(out_ready_i),
    .acc_o(acc1), .count_o(count1)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic beat(input logic [1:0] op, input logic [7:0] a, input logic [7:0] b, input logic last);
    op_i = op;
    a_i = {4{a}};
    b_i = {4{b}};
    last_i = last;
    in_valid_i = 1'b1;
    chk("beat_in_ready", 32'(in_ready0), 32'd1);
    @(posedge clk_i);
    #1;
    in_valid_i = 1'b0;
    last_i = 1'b0;
  endtask

  task automatic wait_out(input string tag);
    int n = 0;
    while (out_valid0 !== 1'b1 && n < 8) begin
      @(posedge clk_i);
      #1;
      n++;
    end
    chk(tag, 32'(out_valid0), 32'd1);
  endtask

  task automatic handshake();
    out_ready_i = 1'b1;
    @(posedge clk_i);
    #1;
    out_ready_i = 1'b0;
    chk("hs_in_ready", 32'(in_ready0), 32'd1);
    chk("hs_out_valid", 32'(out_valid0), 32'd0);
  endtask

  initial begin
    #1;
    chk("rst_acc", 32'(acc0), 32'd0);
    chk("rst_count", 32'(count0), 32'd0);
    chk("rst_out_valid", 32'(out_valid0), 32'd0);
    #11 rst_ni = 1'b1;
    @(posedge clk_i);
    #1;
    chk("post_rst_in_ready", 32'(in_ready0), 32'd1);
    // XNOR: ~(FF^0F)=0F -> 4 per lane -> 16; valid after the edge following acceptance
    beat(2'b00, 8'hFF, 8'h0F, 1'b1);
    chk("xnor_drain_valid", 32'(out_valid0), 32'd0);
    chk("xnor_drain_ready", 32'(in_ready0), 32'd0);
    @(posedge clk_i);
    #1;
    chk("xnor_valid", 32'(out_valid0), 32'd1);
    chk("xnor_acc", 32'(acc0), 32'd16);
    chk("xnor_count", 32'(count0), 32'd1);
    handshake();
    // MUL: -3*5=-15 per lane, -60 per beat, 3 beats = -180
    beat(2'b01, 8'hFD, 8'h05, 1'b0);
    beat(2'b01, 8'hFD, 8'h05, 1'b0);
    beat(2'b01, 8'hFD, 8'h05, 1'b1);
    wait_out("mul_wait");
    chk("mul_acc", 32'(acc0), 32'hFFFF4C);
    chk("mul_count", 32'(count0), 32'd3);
    // backpressure, with an ignored in_valid pulse that must not disturb anything
    in_valid_i = 1'b1;
    a_i = '1;
    b_i = '1;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk_i);
      #1;
      chk("bp_out_valid", 32'(out_valid0), 32'd1);
      chk("bp_acc", 32'(acc0), 32'hFFFF4C);
      chk("bp_in_ready", 32'(in_ready0), 32'd0);
    end
    chk("bp_count", 32'(count0), 32'd3);
    in_valid_i = 1'b0;
    handshake();
    // op latch: XOR(AA,55)=FF -> 32; second beat still XOR of 00,00 -> 0
    beat(2'b10, 8'hAA, 8'h55, 1'b0);
    beat(2'b01, 8'h00, 8'h00, 1'b1);
    wait_out("latch_wait");
    chk("latch_acc", 32'(acc0), 32'd32);
    chk("latch_count", 32'(count0), 32'd2);
    handshake();
    // op latch, discriminating: 03^01 -> 1 per lane -> 4 (MUL would give 12)
    beat(2'b10, 8'h00, 8'h00, 1'b0);
    beat(2'b01, 8'h03, 8'h01, 1'b1);
    wait_out("latch2_wait");
    chk("latch2_acc", 32'(acc0), 32'd4);
    handshake();
    // wrap: 127*127*4=64516 per beat, 2 beats = 129032
    beat(2'b01, 8'h7F, 8'h7F, 1'b0);
    beat(2'b01, 8'h7F, 8'h7F, 1'b1);
    wait_out("wrap_wait");
    chk("wrap_acc16", 32'(acc1), 32'd63496);
    chk("wrap_acc24", 32'(acc0), 32'd129032);
    chk("wrap_count16", 32'(count1), 32'd2);
    handshake();
    // reset mid-vector discards the partial result
    beat(2'b01, 8'h7F, 8'h7F, 1'b0);
    beat(2'b01, 8'h7F, 8'h7F, 1'b0);
    chk("pre_rst_count", 32'(count0), 32'd2);
    rst_ni = 1'b0;
    #1;
    chk("mid_rst_acc", 32'(acc0), 32'd0);
    chk("mid_rst_count", 32'(count0), 32'd0);
    chk("mid_rst_out_valid", 32'(out_valid0), 32'd0);
    #2 rst_ni = 1'b1;
    @(posedge clk_i);
    #1;
    beat(2'b00, 8'hFF, 8'h0F, 1'b1);
    wait_out("rst_vec_wait");
    chk("rst_vec_acc", 32'(acc0), 32'd16);
    chk("rst_vec_count", 32'(count0), 32'd1);
    handshake();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
